load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 14 +
 rtl/load_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_LOAD_ISSUE   = 2'd1,
    ST_LOAD_CAPTURE = 2'd2,
    ST_STORE        = 2'd3
  } lsu_state_e;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

endpackage

// File: rtl/load_store_unit.sv
// CPU-side load/store sequencer driving a registered-read data memory.
// Optional post-increment pointer enabled by defining LSU_AUTOINC_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
`ifdef LSU_AUTOINC_EN
  input  logic                  ptr_load,
  input  logic                  use_ptr,
  output logic [ADDR_WIDTH-1:0] ptr,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_bus
);

  lsu_state_e            r_state;
  lsu_state_e            w_state_nxt;
  logic                  w_accept;
  logic                  w_done_nxt;
  logic [ADDR_WIDTH-1:0] w_eff_addr;

  logic                  r_busy;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_mem_rd_wr;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data_in;

`ifdef LSU_AUTOINC_EN
  logic                  w_ptr_ld;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_use_ptr;
`endif

  // Next-state logic; ptr_load takes priority over req in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
`ifdef LSU_AUTOINC_EN
    w_ptr_ld    = 1'b0;
    w_eff_addr  = use_ptr ? r_ptr : addr;
`else
    w_eff_addr  = addr;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef LSU_AUTOINC_EN
        if (ptr_load) begin
          w_ptr_ld = 1'b1;
        end else
`endif
        if (req) begin
          w_accept    = 1'b1;
          w_state_nxt = we ? ST_STORE : ST_LOAD_ISSUE;
        end
      end
      ST_LOAD_ISSUE:   w_state_nxt = ST_LOAD_CAPTURE;
      ST_LOAD_CAPTURE: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      ST_STORE: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = 1'b1;
      end
      default:         w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs, derived from the next state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_rdata       <= '0;
      r_mem_rd_wr   <= MEM_READ;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= w_done_nxt;
      r_mem_rd_wr <= (w_state_nxt == ST_STORE) ? MEM_WRITE : MEM_READ;
      if (w_accept) begin
        r_mem_address <= w_eff_addr;
        r_mem_data_in <= wdata;
      end
      if (r_state == ST_LOAD_CAPTURE) begin
        r_rdata <= mem_data_bus;
      end
    end
  end

`ifdef LSU_AUTOINC_EN
  // Pointer advances on the completion edge of an access that used it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr     <= '0;
      r_use_ptr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_use_ptr <= use_ptr;
      end
      if (w_ptr_ld) begin
        r_ptr <= addr;
      end else if (w_done_nxt && r_use_ptr) begin
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  assign ptr = r_ptr;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign mem_rd_wr   = r_mem_rd_wr;
  assign mem_address = r_mem_address;
  assign mem_data_in = r_mem_data_in;

endmodule
